// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Two-requester, packet-locked arbiter in front of a uart_tx6 transmit
//   buffer. A requester that wins keeps the grant until it sends a byte
//   flagged "last", or until MAX_PKT bytes have gone without one. In the
//   second case the grant is forcibly released and the sticky pkt_err flag
//   is raised. Ties in IDLE are broken round-robin against the last owner.
//
// Ports
//   clk                      system clock
//   btnCpuReset              asynchronous active-low reset
//   req0_valid / req1_valid  requester offers a byte
//   req0_data  / req1_data   offered byte
//   req0_last  / req1_last   offered byte ends its packet
//   req0_ready / req1_ready  byte accepted this cycle when valid & ready
//   tx_data                  byte to uart_tx6 data_in (registered)
//   tx_write                 one-cycle write strobe to uart_tx6 buffer_write
//   tx_full                  uart_tx6 buffer_full
//   grant                    one-hot current owner, 2'b00 when idle
//   pkt_err                  sticky: a packet was cut off at MAX_PKT bytes
//   err_clr                  synchronous clear of pkt_err (a new set wins)
module uart_tx_arbiter #(
    parameter int unsigned MAX_PKT = 64
) (
    input  logic       clk,
    input  logic       btnCpuReset,
    input  logic       req0_valid,
    input  logic       req1_valid,
    input  logic [7:0] req0_data,
    input  logic [7:0] req1_data,
    input  logic       req0_last,
    input  logic       req1_last,
    output logic       req0_ready,
    output logic       req1_ready,
    output logic [7:0] tx_data,
    output logic       tx_write,
    input  logic       tx_full,
    output logic [1:0] grant,
    output logic       pkt_err,
    input  logic       err_clr
);

    localparam logic [7:0] MAX_PKT_B = 8'(MAX_PKT);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    state_e     state_q, state_d;
    logic       owner_q, owner_d;
    logic       rr_q, rr_d;
    logic [7:0] cnt_q, cnt_d;
    logic       tx_write_q, tx_write_d;
    logic [7:0] tx_data_q, tx_data_d;
    logic       pkt_err_q, pkt_err_d;

    logic       sel_valid;
    logic [7:0] sel_data;
    logic       sel_last;
    logic       can_accept;
    logic       accept;
    logic [7:0] cnt_inc;

    always_ff @(posedge clk or negedge btnCpuReset) begin
        if (!btnCpuReset) begin
            state_q    <= ST_IDLE;
            owner_q    <= 1'b0;
            rr_q       <= 1'b1;
            cnt_q      <= 8'h00;
            tx_write_q <= 1'b0;
            tx_data_q  <= 8'h00;
            pkt_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            rr_q       <= rr_d;
            cnt_q      <= cnt_d;
            tx_write_q <= tx_write_d;
            tx_data_q  <= tx_data_d;
            pkt_err_q  <= pkt_err_d;
        end
    end

    always_comb begin
        sel_valid = owner_q ? req1_valid : req0_valid;
        sel_data  = owner_q ? req1_data  : req0_data;
        sel_last  = owner_q ? req1_last  : req0_last;

        // Blocking on tx_write_q means a byte written last cycle is already
        // reflected in tx_full before the next one is accepted.
        can_accept = (state_q == ST_BUSY) && !tx_full && !tx_write_q;
        req0_ready = can_accept && !owner_q;
        req1_ready = can_accept &&  owner_q;
        accept     = can_accept && sel_valid;

        cnt_inc = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;

        state_d    = state_q;
        owner_d    = owner_q;
        rr_d       = rr_q;
        cnt_d      = cnt_q;
        tx_write_d = 1'b0;
        tx_data_d  = tx_data_q;
        pkt_err_d  = err_clr ? 1'b0 : pkt_err_q;

        case (state_q)
            ST_IDLE: begin
                if (req0_valid || req1_valid) begin
                    state_d = ST_BUSY;
                    cnt_d   = 8'h00;
                    // On a tie the requester that was not served last wins.
                    if (req0_valid && req1_valid) begin
                        owner_d = ~rr_q;
                    end else begin
                        owner_d = req1_valid;
                    end
                end
            end
            ST_BUSY: begin
                if (accept) begin
                    tx_write_d = 1'b1;
                    tx_data_d  = sel_data;
                    cnt_d      = cnt_inc;
                    if (sel_last) begin
                        state_d = ST_IDLE;
                        rr_d    = owner_q;
                    end else if (cnt_inc == MAX_PKT_B) begin
                        state_d   = ST_IDLE;
                        rr_d      = owner_q;
                        pkt_err_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign grant    = (state_q == ST_BUSY) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
    assign tx_write = tx_write_q;
    assign tx_data  = tx_data_q;
    assign pkt_err  = pkt_err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;

    logic       clk = 1'b0;
    logic       btnCpuReset = 1'b1;
    logic       req0_valid = 1'b0, req1_valid = 1'b0;
    logic [7:0] req0_data = 8'h00, req1_data = 8'h00;
    logic       req0_last = 1'b0, req1_last = 1'b0;
    logic       tx_full = 1'b0;
    logic       err_clr = 1'b0;

    logic       req0_ready, req1_ready, tx_write, pkt_err;
    logic [7:0] tx_data;
    logic [1:0] grant;
    logic       req0_ready4, req1_ready4, tx_write4, pkt_err4;
    logic [7:0] tx_data4;
    logic [1:0] grant4;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] q0[$], q1[$];
    bit         l0[$], l1[$];
    bit         en0, en1, sel4;
    logic [7:0] got[$], got4[$];
    int         st[$];
    int         cyc = 0;
    bit         err_at4, idle_after4, prev_w;
    logic [1:0] neg_grant;
    int         viol = 0;

    always #5 clk = ~clk;

    uart_tx_arbiter u_dut (
        .clk(clk), .btnCpuReset(btnCpuReset),
        .req0_valid(req0_valid), .req1_valid(req1_valid),
        .req0_data(req0_data), .req1_data(req1_data),
        .req0_last(req0_last), .req1_last(req1_last),
        .req0_ready(req0_ready), .req1_ready(req1_ready),
        .tx_data(tx_data), .tx_write(tx_write), .tx_full(tx_full),
        .grant(grant), .pkt_err(pkt_err), .err_clr(err_clr)
    );

    uart_tx_arbiter #(.MAX_PKT(4)) u_dut4 (
        .clk(clk), .btnCpuReset(btnCpuReset),
        .req0_valid(req0_valid), .req1_valid(req1_valid),
        .req0_data(req0_data), .req1_data(req1_data),
        .req0_last(req0_last), .req1_last(req1_last),
        .req0_ready(req0_ready4), .req1_ready(req1_ready4),
        .tx_data(tx_data4), .tx_write(tx_write4), .tx_full(tx_full),
        .grant(grant4), .pkt_err(pkt_err4), .err_clr(err_clr)
    );

    task automatic apply();
        req0_valid = en0 && (q0.size() > 0);
        req0_data  = (q0.size() > 0) ? q0[0] : 8'h00;
        req0_last  = (l0.size() > 0) ? l0[0] : 1'b0;
        req1_valid = en1 && (q1.size() > 0);
        req1_data  = (q1.size() > 0) ? q1[0] : 8'h00;
        req1_last  = (l1.size() > 0) ? l1[0] : 1'b0;
    endtask

    task automatic push0(input logic [7:0] d, input bit l);
        q0.push_back(d); l0.push_back(l);
    endtask

    task automatic push1(input logic [7:0] d, input bit l);
        q1.push_back(d); l1.push_back(l);
    endtask

    // One clock: sample at negedge, advance the byte sources after the edge.
    task automatic drive_cycle();
        bit a0, a1;
        @(negedge clk);
        cyc++;
        if (tx_write) begin got.push_back(tx_data); st.push_back(cyc); end
        if (tx_write4) begin
            got4.push_back(tx_data4);
            if (got4.size() == 4) err_at4 = pkt_err4;
        end
        if (got4.size() == 4 && grant4 == 2'b00) idle_after4 = 1'b1;
        neg_grant = grant;
        if ((req0_ready || req1_ready) && tx_full) viol++;
        if (req0_ready && req1_ready) viol++;
        if (tx_write && prev_w) viol++;
        prev_w = tx_write;
        a0 = req0_valid && (sel4 ? req0_ready4 : req0_ready);
        a1 = req1_valid && (sel4 ? req1_ready4 : req1_ready);
        @(posedge clk);
        #1;
        if (a0) begin void'(q0.pop_front()); void'(l0.pop_front()); end
        if (a1) begin void'(q1.pop_front()); void'(l1.pop_front()); end
        apply();
    endtask

    task automatic do_reset();
        btnCpuReset = 1'b0;
        en0 = 0; en1 = 0; sel4 = 0;
        q0.delete(); l0.delete(); q1.delete(); l1.delete();
        tx_full = 1'b0; err_clr = 1'b0;
        apply();
        got.delete(); got4.delete(); st.delete();
        err_at4 = 0; idle_after4 = 0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic release_reset();
        @(negedge clk);
        btnCpuReset = 1'b1;
    endtask

    task automatic test_reset();
        btnCpuReset = 1'b1;
        #1;
        btnCpuReset = 1'b0;
        #1;
        vectors++; if (grant !== 2'b00) begin miscompares++; $display("FAIL rst_grant: got %b expected 00", grant); end
        vectors++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin miscompares++; $display("FAIL rst_ready: got %b%b expected 00", req0_ready, req1_ready); end
        vectors++; if (tx_write !== 1'b0) begin miscompares++; $display("FAIL rst_tx_write: got %b expected 0", tx_write); end
        vectors++; if (tx_data !== 8'h00) begin miscompares++; $display("FAIL rst_tx_data: got %h expected 00", tx_data); end
        vectors++; if (pkt_err !== 1'b0) begin miscompares++; $display("FAIL rst_pkt_err: got %b expected 0", pkt_err); end
        push0(8'h11, 1'b1); en0 = 1; apply();
        @(posedge clk); #1;
        vectors++; if (grant !== 2'b00) begin miscompares++; $display("FAIL rst_hold_grant: got %b expected 00", grant); end
        do_reset();
    endtask

    task automatic test_hello();
        logic [7:0] exp_b [5] = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F};
        logic [7:0] act;
        int         gap;
        bit         seen01 = 0;
        int         bad_grant = 0;
        do_reset();
        for (int i = 0; i < 5; i++) push0(exp_b[i], i == 4);
        en0 = 1; apply(); release_reset();
        for (int i = 0; i < 60 && got.size() < 5; i++) begin
            drive_cycle();
            if (neg_grant == 2'b01) seen01 = 1;
            if (neg_grant == 2'b10) bad_grant++;
        end
        drive_cycle(); drive_cycle();
        vectors++; if (got.size() !== 5) begin miscompares++; $display("FAIL hello_count: got %0d expected 5", got.size()); end
        for (int i = 0; i < 5; i++) begin
            act = (i < got.size()) ? got[i] : 8'hxx;
            vectors++; if (act !== exp_b[i]) begin miscompares++; $display("FAIL hello_byte%0d: got %h expected %h", i, act, exp_b[i]); end
        end
        for (int i = 1; i < 5; i++) begin
            gap = (i < st.size()) ? st[i] - st[i-1] : -1;
            vectors++; if (gap !== 2) begin miscompares++; $display("FAIL hello_gap%0d: got %0d expected 2", i, gap); end
        end
        vectors++; if (!seen01 || bad_grant != 0) begin miscompares++; $display("FAIL hello_grant_seq: got seen01=%0d bad=%0d expected 1/0", seen01, bad_grant); end
        vectors++; if (grant !== 2'b00) begin miscompares++; $display("FAIL hello_grant_end: got %b expected 00", grant); end
        vectors++; if (pkt_err !== 1'b0) begin miscompares++; $display("FAIL hello_pkt_err: got %b expected 0", pkt_err); end
    endtask

    task automatic test_contention();
        logic [7:0] exp_b [9] = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h48, 8'h49, 8'h46, 8'h47};
        logic [7:0] act;
        int         gap;
        do_reset();
        push0(8'h41, 0); push0(8'h42, 1);
        push1(8'h43, 0); push1(8'h44, 1);
        en0 = 1; en1 = 1; apply(); release_reset();
        for (int i = 0; i < 60 && got.size() < 4; i++) drive_cycle();
        gap = (st.size() >= 3) ? st[2] - st[1] : -1;
        vectors++; if (gap !== 2) begin miscompares++; $display("FAIL cont_switch_gap: got %0d expected 2", gap); end
        drive_cycle(); drive_cycle();
        // req0 alone leaves rr pointing at requester 0.
        push0(8'h45, 1); apply();
        for (int i = 0; i < 30 && got.size() < 5; i++) drive_cycle();
        drive_cycle();
        push0(8'h46, 0); push0(8'h47, 1);
        push1(8'h48, 0); push1(8'h49, 1);
        apply();
        for (int i = 0; i < 60 && got.size() < 9; i++) drive_cycle();
        vectors++; if (got.size() !== 9) begin miscompares++; $display("FAIL cont_count: got %0d expected 9", got.size()); end
        for (int i = 0; i < 9; i++) begin
            act = (i < got.size()) ? got[i] : 8'hxx;
            vectors++; if (act !== exp_b[i]) begin miscompares++; $display("FAIL cont_byte%0d: got %h expected %h", i, act, exp_b[i]); end
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] act;
        int         bad = 0;
        do_reset();
        for (int i = 0; i < 6; i++) push0(8'h10 + 8'(i), i == 5);
        en0 = 1; apply(); release_reset();
        for (int i = 0; i < 40 && got.size() < 2; i++) drive_cycle();
        tx_full = 1'b1;
        for (int i = 0; i < 20; i++) begin
            drive_cycle();
            if (req0_ready !== 1'b0 || req1_ready !== 1'b0 || tx_write !== 1'b0) bad++;
        end
        vectors++; if (bad !== 0) begin miscompares++; $display("FAIL bp_stall: got %0d active cycles expected 0", bad); end
        vectors++; if (got.size() !== 2) begin miscompares++; $display("FAIL bp_held_count: got %0d expected 2", got.size()); end
        tx_full = 1'b0;
        for (int i = 0; i < 40 && got.size() < 6; i++) drive_cycle();
        drive_cycle(); drive_cycle();
        vectors++; if (got.size() !== 6) begin miscompares++; $display("FAIL bp_count: got %0d expected 6", got.size()); end
        for (int i = 0; i < 6; i++) begin
            act = (i < got.size()) ? got[i] : 8'hxx;
            vectors++; if (act !== 8'h10 + 8'(i)) begin miscompares++; $display("FAIL bp_byte%0d: got %h expected %h", i, act, 8'h10 + 8'(i)); end
        end
    endtask

    task automatic test_overrun();
        logic [7:0] act;
        do_reset();
        sel4 = 1;
        for (int i = 0; i < 6; i++) push1(8'h60 + 8'(i), 1'b0);
        en1 = 1; apply(); release_reset();
        for (int i = 0; i < 80 && got4.size() < 6; i++) drive_cycle();
        drive_cycle();
        vectors++; if (got4.size() !== 6) begin miscompares++; $display("FAIL ovr_count: got %0d expected 6", got4.size()); end
        for (int i = 0; i < 6; i++) begin
            act = (i < got4.size()) ? got4[i] : 8'hxx;
            vectors++; if (act !== 8'h60 + 8'(i)) begin miscompares++; $display("FAIL ovr_byte%0d: got %h expected %h", i, act, 8'h60 + 8'(i)); end
        end
        vectors++; if (err_at4 !== 1'b1) begin miscompares++; $display("FAIL ovr_err_at4: got %b expected 1", err_at4); end
        vectors++; if (idle_after4 !== 1'b1) begin miscompares++; $display("FAIL ovr_idle: got %b expected 1", idle_after4); end
        vectors++; if (pkt_err4 !== 1'b1) begin miscompares++; $display("FAIL ovr_sticky: got %b expected 1", pkt_err4); end
        vectors++; if (pkt_err !== 1'b0) begin miscompares++; $display("FAIL ovr_main_err: got %b expected 0", pkt_err); end
        err_clr = 1'b1;
        drive_cycle();
        err_clr = 1'b0;
        vectors++; if (pkt_err4 !== 1'b0) begin miscompares++; $display("FAIL ovr_clear: got %b expected 0", pkt_err4); end
        // Clear held high across the forced release: the set must win.
        do_reset();
        sel4 = 1; err_clr = 1'b1;
        for (int i = 0; i < 4; i++) push1(8'h70 + 8'(i), 1'b0);
        en1 = 1; apply(); release_reset();
        for (int i = 0; i < 60 && got4.size() < 4; i++) drive_cycle();
        vectors++; if (err_at4 !== 1'b1) begin miscompares++; $display("FAIL set_wins: got %b expected 1", err_at4); end
        vectors++; if (pkt_err4 !== 1'b0) begin miscompares++; $display("FAIL set_then_clear: got %b expected 0", pkt_err4); end
        err_clr = 1'b0;
        sel4 = 0;
    endtask

    task automatic test_lock();
        logic [7:0] exp_b [6] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h41, 8'h42};
        logic [7:0] act;
        int         bad = 0;
        do_reset();
        for (int i = 0; i < 4; i++) push0(exp_b[i], i == 3);
        push1(8'h41, 0); push1(8'h42, 1);
        en0 = 1; en1 = 1; apply(); release_reset();
        for (int i = 0; i < 40 && got.size() < 2; i++) drive_cycle();
        en0 = 0; apply();
        for (int i = 0; i < 50; i++) begin
            drive_cycle();
            if (grant !== 2'b01 || req1_ready !== 1'b0) bad++;
        end
        vectors++; if (bad !== 0) begin miscompares++; $display("FAIL lock_hold: got %0d bad cycles expected 0", bad); end
        vectors++; if (got.size() !== 2) begin miscompares++; $display("FAIL lock_no_write: got %0d expected 2", got.size()); end
        en0 = 1; apply();
        for (int i = 0; i < 60 && got.size() < 6; i++) drive_cycle();
        for (int i = 0; i < 6; i++) begin
            act = (i < got.size()) ? got[i] : 8'hxx;
            vectors++; if (act !== exp_b[i]) begin miscompares++; $display("FAIL lock_byte%0d: got %h expected %h", i, act, exp_b[i]); end
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] act;
        do_reset();
        for (int i = 0; i < 8; i++) push0(8'h80 + 8'(i), i == 7);
        en0 = 1; apply(); release_reset();
        for (int i = 0; i < 40 && got.size() < 2; i++) drive_cycle();
        #2;
        btnCpuReset = 1'b0;
        #1;
        vectors++; if (req0_ready !== 1'b0) begin miscompares++; $display("FAIL mid_ready: got %b expected 0", req0_ready); end
        vectors++; if (grant !== 2'b00) begin miscompares++; $display("FAIL mid_grant: got %b expected 00", grant); end
        vectors++; if (tx_data !== 8'h00) begin miscompares++; $display("FAIL mid_tx_data: got %h expected 00", tx_data); end
        vectors++; if (tx_write !== 1'b0) begin miscompares++; $display("FAIL mid_tx_write: got %b expected 0", tx_write); end
        repeat (3) drive_cycle();
        vectors++; if (got.size() !== 2) begin miscompares++; $display("FAIL mid_no_write: got %0d expected 2", got.size()); end
        q0.delete(); l0.delete();
        push0(8'h90, 0); push0(8'h91, 1);
        apply(); release_reset();
        drive_cycle();
        vectors++; if (neg_grant !== 2'b01) begin miscompares++; $display("FAIL mid_first_grant: got %b expected 01", neg_grant); end
        for (int i = 0; i < 40 && got.size() < 4; i++) drive_cycle();
        for (int i = 0; i < 2; i++) begin
            act = (i + 2 < got.size()) ? got[i+2] : 8'hxx;
            vectors++; if (act !== 8'h90 + 8'(i)) begin miscompares++; $display("FAIL mid_new_byte%0d: got %h expected %h", i, act, 8'h90 + 8'(i)); end
        end
    endtask

    task automatic test_invariants();
        vectors++; if (viol !== 0) begin miscompares++; $display("FAIL invariants: got %0d violations expected 0", viol); end
    endtask

    initial begin
        test_reset();
        test_hello();
        test_contention();
        test_backpressure();
        test_overrun();
        test_lock();
        test_reset_mid();
        test_invariants();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 The block SHALL have parameter MAX_PKT, default 64, giving the maximum bytes per grant before a forced release (legal range 2..255).
REQ-002 The block SHALL have port clk, input, 1, the system clock (100 MHz).
REQ-003 The block SHALL have port btnCpuReset, input, 1, the reset; one clock, reset asynchronous and active-low.
REQ-004 The block SHALL have ports req0_valid and req1_valid, input, 1 each, requester has a byte offered.
REQ-005 The block SHALL have ports req0_data and req1_data, input, 8 each, the offered byte.
REQ-006 The block SHALL have ports req0_last and req1_last, input, 1 each, the offered byte ends a packet.
REQ-007 The block SHALL have ports req0_ready and req1_ready, output, 1 each, the byte is accepted this cycle when valid and ready are both high.
REQ-008 The block SHALL have port tx_data, output, 8, which connects to data_in of uart_tx6.
REQ-009 The block SHALL have port tx_write, output, 1, which connects to buffer_write of uart_tx6.
REQ-010 The block SHALL have port tx_full, input, 1, which connects to buffer_full of uart_tx6.
REQ-011 The block SHALL have port grant, output, 2, the one-hot current owner; 2'b00 when idle.
REQ-012 The block SHALL have port pkt_err, output, 1, a sticky flag for a forced release.
REQ-013 The block SHALL have port err_clr, input, 1, a synchronous clear of pkt_err.

Function
REQ-014 The block SHALL implement states IDLE and BUSY, plus an owner register (0/1), a round-robin pointer rr (last owner served), an 8-bit byte counter cnt, and a registered tx_write/tx_data pair.
REQ-015 In IDLE with exactly one reqN_valid high, the block SHALL enter BUSY on the next edge with owner=N, cnt=0, and grant one-hot for N.
REQ-016 In IDLE with both valids high, the block SHALL grant the requester not equal to rr; after reset rr=1, so requester 0 wins first.
REQ-017 In IDLE, all reqN_ready SHALL be 0; no byte is accepted in the cycle a grant is decided.
REQ-018 In BUSY, readyN SHALL be the combinational result of (owner==N) AND NOT tx_full AND NOT tx_write; the non-owner ready SHALL be 0.
REQ-019 On an accept, the block SHALL register tx_data equal to the owner's data, and tx_write SHALL be 1 for exactly the following cycle.
REQ-020 The maximum throughput SHALL therefore be one byte per 2 clocks, and no write SHALL ever be issued while tx_full is high.
REQ-021 Each accept SHALL increment cnt, with saturating width rules; cnt never wraps because MAX_PKT <= 255.
REQ-022 An accept with last=1 SHALL cause BUSY->IDLE on that edge, with rr set to owner; grant SHALL read 00 on the next cycle.
REQ-023 An accept with last=0 that makes cnt equal MAX_PKT SHALL cause BUSY->IDLE, set rr to owner, and set pkt_err=1.
REQ-024 The packet lock SHALL hold: the owner dropping valid mid-packet keeps BUSY indefinitely with the grant unchanged; the other requester stays stalled.
REQ-025 The owner's last byte SHALL be accepted normally even when the other requester is valid; re-arbitration takes place in the following IDLE cycle.
REQ-026 When tx_full is high, ready SHALL be held 0; the accept resumes in the first cycle where tx_full=0 and tx_write=0.
REQ-027 When err_clr and a new forced release coincide, set SHALL win and pkt_err stays 1.
REQ-028 Each grant SHALL cost exactly one IDLE cycle, so the minimum gap between packets from different requesters is 1 arbitration cycle plus 1 cycle.
REQ-029 The block SHALL have no combinational path from tx_full to tx_write; a path from tx_full to ready is allowed.

Reset
REQ-030 While btnCpuReset=0, asynchronously and immediately, the block SHALL force state=IDLE, grant=00, req0_ready=req1_ready=0, tx_write=0, tx_data=8'h00, cnt=0, rr=1, pkt_err=0.
REQ-031 A reset mid-packet SHALL drop the packet with no further tx_write; bytes already written to uart_tx6 are not recalled.
REQ-032 The first grant is possible on the first clock edge after btnCpuReset returns to 1.

Verification
REQ-033 The bench SHALL cover the single-requester scenario: req0 sends "HELLO" (48 45 4C 4C 4F), with last on 4F -> five tx_write pulses in order, two clocks apart, grant 01 then 00, and pkt_err=0.
REQ-034 The bench SHALL cover the contention scenario: both valid from reset, req0 sends "AB", req1 sends "CD" -> UART output "ABCD"; a second round with both valid -> req1 first, because rr=0.
REQ-035 The bench SHALL cover the backpressure scenario: tx_full forced to 1 for 20 clocks mid-packet -> readys stay 0 and tx_write stays 0, then transfer resumes with no byte lost or duplicated.
REQ-036 The bench SHALL cover the overrun scenario: with MAX_PKT=4, req1 streams 6 bytes without last -> 4 writes, then IDLE, pkt_err=1; err_clr pulse -> pkt_err=0.
REQ-037 The bench SHALL cover the lock scenario: req0 drops valid after byte 2 for 50 clocks while req1 is valid -> grant stays 01 and req1_ready stays 0; when req0 completes, req1 is served.
REQ-038 The bench SHALL cover reset mid-packet: btnCpuReset pulled low during byte 3 of 8 -> all outputs go to reset values within the same cycle, and a new packet is accepted after release.
